// File: rtl/diff_locator_seq.sv
// diff_locator_seq
//   Finds the 1-based position of the lowest (mode=0) or highest (mode=1)
//   bit where operands a and b differ. The XOR of the operands is scanned
//   one SLICE-bit slice per cycle, and the scan stops at the first nonzero
//   slice. When the operands match, pos=0 and equal=1.
//
//   Handshake: start is sampled only in IDLE, and a, b and mode are latched
//   with it. busy is high while scanning. done pulses for one cycle, and pos
//   and equal are valid during that pulse. pos and equal then hold until the
//   next search resolves. start seen while busy or during done is dropped.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, mode     : search request and direction (0 lowest, 1 highest)
//   a, b            : operands (WIDTH bits)
//   busy, done      : scan in progress / one-cycle result strobe
//   pos, equal      : result position (POS_W bits) and equality flag
module diff_locator_seq #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16,
   parameter int POS_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [POS_W-1:0] pos,
   output logic             equal
);

   localparam int NS = WIDTH / SLICE;
   localparam int IW = $clog2(SLICE);
   localparam int PW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [PW-1:0] LAST_UP = PW'(NS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [WIDTH-1:0]  x;
   logic              m;
   logic [PW-1:0]     ptr;

   logic [SLICE-1:0]  s;
   logic [IW-1:0]     lo_idx, hi_idx, idx;
   logic              last;
   logic              load, advance, resolve;
   logic [POS_W-1:0]  hit_pos;

   // Slice currently under the pointer.
   assign s = x[int'(ptr) * SLICE +: SLICE];

   // Find the lowest and highest set bit in the slice. The two loops run in
   // opposite directions so that the last write wins.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      for (int i = SLICE - 1; i >= 0; i--) begin
         if (s[i]) lo_idx = IW'(i);
      end
      for (int i = 0; i < SLICE; i++) begin
         if (s[i]) hi_idx = IW'(i);
      end
   end

   assign idx     = m ? hi_idx : lo_idx;
   // ptr*SLICE + idx is just the concatenation {ptr, idx}.
   assign hit_pos = POS_W'({ptr, idx}) + POS_W'(1);
   assign last    = m ? (ptr == '0) : (ptr == LAST_UP);

   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      resolve    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if ((s != '0) || last) begin
               resolve    = 1'b1;
               state_next = DONE;
            end else begin
               advance    = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         m     <= 1'b0;
         ptr   <= '0;
         pos   <= '0;
         equal <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            x   <= a ^ b;
            m   <= mode;
            ptr <= mode ? LAST_UP : '0;
         end
         if (advance) begin
            ptr <= m ? (ptr - PW'(1)) : (ptr + PW'(1));
         end
         if (resolve) begin
            pos   <= (s != '0) ? hit_pos : '0;
            equal <= (s == '0);
         end
      end
   end

   assign busy = (state == SCAN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_diff_locator_seq.sv
// Directed bench for diff_locator_seq with WIDTH=64 and SLICE=16.
module tb_diff_locator_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [6:0]  pos;
  logic        equal;

  int n_tests = 0;
  int n_fail  = 0;

  diff_locator_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .pos   (pos),
    .equal (equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of edges after E0 until done is seen, or 99 if it never appears.
  task automatic wait_done(output int n);
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      n++;
      if (done) return;
    end
    n = 99;
  endtask

  task automatic run(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                     input logic tm, input int ep, input int ee, input int el);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs to confirm the search uses the latched copies.
    a = ~ta; b = tb_v ^ 64'h5A5A_0F0F_3C3C_9696; mode = ~tm;
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, "_lat"},   64'(n),     64'(el));
    check({tag, "_pos"},   64'(pos),   64'(ep));
    check({tag, "_equal"}, 64'(equal), 64'(ee));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_pos_hold"},   64'(pos),  64'(ep));
  endtask

  initial begin
    int n;
    int extra;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_pos",   64'(pos),   64'd0);
    check("rst_equal", 64'(equal), 64'd0);
    @(negedge clk); rst = 1'b0;

    run("eq_m0", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1, 4);
    run("eq_m1", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1, 4);
    run("low1",  64'h0, 64'h1, 1'b0, 1, 0, 1);
    run("msb_m0", 64'h0, 64'h8000_0000_0000_0000, 1'b0, 64, 0, 4);
    run("msb_m1", 64'h0, 64'h8000_0000_0000_0000, 1'b1, 64, 0, 1);
    run("mix_m0", 64'h0, 64'h0000_0001_0010_0000, 1'b0, 21, 0, 2);
    run("mix_m1", 64'h0, 64'h0000_0001_0010_0000, 1'b1, 33, 0, 2);

    // start is held high through SCAN and DONE. A second search begins only
    // once the block is back in IDLE, and it uses the operands present then.
    @(negedge clk);
    a = 64'h0; b = 64'h1_0000; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 64'h0; b = 64'h2;
    wait_done(n);
    check("hold_lat", 64'(n),   64'd2);
    check("hold_pos", 64'(pos), 64'd17);
    @(posedge clk); #1;
    check("hold_no_dup_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (busy) break;
      @(posedge clk); #1;
    end
    check("hold_second_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(n);
    check("hold_second_pos",   64'(pos),   64'd2);
    check("hold_second_equal", 64'(equal), 64'd0);
    @(posedge clk); #1;

    // Reset during a scan aborts the search without a done pulse.
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'hFFFF_0000_FFFF_0000; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;             // E0
    start = 1'b0;
    @(posedge clk); #1;             // E1
    @(posedge clk); #1;             // E2
    rst = 1'b1;
    @(posedge clk); #1;             // E3
    rst = 1'b0;
    check("rst_mid_busy",  64'(busy),  64'd0);
    check("rst_mid_done",  64'(done),  64'd0);
    check("rst_mid_pos",   64'(pos),   64'd0);
    check("rst_mid_equal", 64'(equal), 64'd0);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("rst_mid_no_done", 64'(extra), 64'd0);
    run("after_rst", 64'h0, 64'h2, 1'b0, 2, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
